dma_axi_write_engine: RTL and testbench

// Downstream partner of the DMA read engine. Pops the read-data FIFO ({packet_complete,last,data}), splits a descriptor into AXI4 INCR write bursts to the destination, and counts B responses.

---
 rtl/dma_axi_write_engine_if.sv | 33 +++
 rtl/dma_axi_write_engine.sv | 134 +++++++++++++
 tb/tb_dma_axi_write_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_axi_write_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write engine and the destination.
interface dma_axi_write_engine_if #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int AXI_LEN_W = 8
);
  logic                   awvalid;
  logic                   awready;
  logic [ADDR_W-1:0]      awaddr;
  logic [AXI_LEN_W-1:0]   awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   wvalid;
  logic                   wready;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wlast;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/dma_axi_write_engine.sv
// Drains the read-data FIFO into AXI4 INCR write bursts for one descriptor and
// pulses wr_fsm_done once every beat is written and every B response is back.
module dma_axi_write_engine #(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int AXI_LEN_W = 8,
  parameter int LENGTH_W  = 32,
  parameter int MAX_PEND  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  desc_valid,
  input  logic [ADDR_W-1:0]     desc_dst_addr,
  input  logic [LENGTH_W-1:0]   desc_length,
  output logic                  wr_fsm_done,
  input  logic                  fifo_empty,
  input  logic [DATA_W+1:0]     fifo_rd_data,
  output logic                  fifo_rd_en,
  dma_axi_write_engine_if.master axi,
  output logic                  busy,
  output logic                  wr_rsp_err,
  output logic                  seq_err
);

  typedef enum logic [2:0] {IDLE, ADDR_SETUP, SEND_AW, SEND_DATA, WAIT_BRESP, DONE} state_t;

  localparam logic [ADDR_W-1:0]   BURST_BYTES = ADDR_W'(DATA_W / 8) << AXI_LEN_W;
  localparam logic [LENGTH_W-1:0] PEND_LIM    = LENGTH_W'(MAX_PEND);
  localparam logic [LENGTH_W-1:0] ONE         = LENGTH_W'(1);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [LENGTH_W-1:0]    length, nb, aw_cnt, b_cnt, beats;
  logic [LENGTH_W-1:0]    len_m1, b_cnt_nxt;
  logic [AXI_LEN_W-1:0]   beat, blen, awlen_cur;
  logic                   awvalid, wvalid, wlast;
  logic                   aw_fire, w_fire, b_fire;
  logic                   unused_fifo_last;

  assign len_m1    = length - ONE;
  assign b_fire    = axi.bvalid && (state != IDLE);
  assign b_cnt_nxt = b_cnt + LENGTH_W'(b_fire);
  // Only the final burst is short; a remainder of zero means a full final burst.
  assign awlen_cur = (aw_cnt == nb - ONE) ? len_m1[AXI_LEN_W-1:0] : '1;
  assign wlast     = (beat == blen);
  assign aw_fire   = awvalid && axi.awready;
  assign w_fire    = wvalid && axi.wready;

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    case (state)
      IDLE:       if (desc_valid) state_nxt = ADDR_SETUP;
      ADDR_SETUP: if ((aw_cnt - b_cnt_nxt) < PEND_LIM) state_nxt = SEND_AW;
      SEND_AW: begin
        awvalid = 1'b1;
        if (axi.awready) state_nxt = SEND_DATA;
      end
      SEND_DATA: begin
        wvalid = !fifo_empty;
        if (wvalid && axi.wready && wlast)
          state_nxt = (aw_cnt < nb) ? ADDR_SETUP : WAIT_BRESP;
      end
      WAIT_BRESP: if (b_cnt_nxt == nb) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      length     <= '0;
      nb         <= '0;
      aw_cnt     <= '0;
      b_cnt      <= '0;
      beats      <= '0;
      beat       <= '0;
      blen       <= '0;
      wr_rsp_err <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (desc_valid) begin
          addr       <= desc_dst_addr;
          length     <= desc_length;
          nb         <= ((desc_length - ONE) >> AXI_LEN_W) + ONE;
          aw_cnt     <= '0;
          b_cnt      <= '0;
          beats      <= '0;
          beat       <= '0;
          wr_rsp_err <= 1'b0;
          seq_err    <= 1'b0;
        end
      end else begin
        if (b_fire) begin
          b_cnt <= b_cnt_nxt;
          if (axi.bresp != 2'b00) wr_rsp_err <= 1'b1;
        end
        if (aw_fire) begin
          aw_cnt <= aw_cnt + ONE;
          addr   <= addr + BURST_BYTES;
          blen   <= awlen_cur;
        end
        if (w_fire) begin
          beat  <= wlast ? '0 : beat + AXI_LEN_W'(1);
          beats <= beats + ONE;
          // packet_complete must mark exactly the last beat of the descriptor
          if ((beats == len_m1) != fifo_rd_data[DATA_W+1]) seq_err <= 1'b1;
        end
      end
    end
  end

  assign unused_fifo_last = fifo_rd_data[DATA_W];

  assign axi.awvalid  = awvalid;
  assign axi.awaddr   = addr;
  assign axi.awlen    = awlen_cur;
  assign axi.awsize   = 3'($clog2(DATA_W / 8));
  assign axi.awburst  = 2'b01;
  assign axi.wvalid   = wvalid;
  assign axi.wdata    = fifo_rd_data[DATA_W-1:0];
  assign axi.wstrb    = '1;
  assign axi.wlast    = (state == SEND_DATA) && wlast;
  assign axi.bready   = 1'b1;
  assign fifo_rd_en   = w_fire;
  assign wr_fsm_done  = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dma_axi_write_engine.sv
// Randomized bench for dma_axi_write_engine: a FIFO/AXI-slave model plus a
// burst-plan reference derived from (addr, length) checks every AW, W and B.
module tb_dma_axi_write_engine;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int NW = 32;
  localparam logic [AW-1:0] BURST = 64'h4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           desc_valid = 1'b0;
  logic [AW-1:0]  desc_dst_addr = '0;
  logic [NW-1:0]  desc_length = '0;
  logic           wr_fsm_done, fifo_empty, fifo_rd_en, busy, wr_rsp_err, seq_err;
  logic [DW+1:0]  fifo_rd_data;

  dma_axi_write_engine_if #(.DATA_W(DW), .ADDR_W(AW), .AXI_LEN_W(LW)) axi ();

  dma_axi_write_engine #(.DATA_W(DW), .ADDR_W(AW), .AXI_LEN_W(LW), .LENGTH_W(NW), .MAX_PEND(2)) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_dst_addr(desc_dst_addr), .desc_length(desc_length),
    .wr_fsm_done(wr_fsm_done),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .axi(axi),
    .busy(busy), .wr_rsp_err(wr_rsp_err), .seq_err(seq_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW+1:0] q[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];
  int            b_due[$];
  int            b_idx[$];
  int cyc = 0;
  int n_aw, n_w, n_b, n_pop, n_done, n_wl, aw_beats, max_pend, rd_bad;
  bit gap_en = 1'b0;
  bit bhold  = 1'b0;
  int err_burst = -1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete(); exp_data.delete(); exp_last.delete(); exp_addr.delete(); exp_len.delete();
    b_due.delete(); b_idx.delete();
    n_aw = 0; n_w = 0; n_b = 0; n_pop = 0; n_done = 0; n_wl = 0;
    aw_beats = 0; max_pend = 0; rd_bad = 0;
  endtask

  // pc_mode: 0 correct packet_complete, 1 missing on final beat, 2 extra on beat 0
  task automatic start_desc(input logic [AW-1:0] a, input int len, input int pc_mode);
    logic [DW-1:0] d;
    logic pc, lst;
    model_clear();
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      pc  = (i == len - 1);
      if (pc_mode == 1 && i == len - 1) pc = 1'b0;
      if (pc_mode == 2 && i == 0) pc = 1'b1;
      lst = ((i % 256) == 255) || (i == len - 1);
      q.push_back({pc, lst, d});
      exp_data.push_back(d);
      exp_last.push_back(lst);
    end
    for (int b = 0; b * 256 < len; b++) begin
      exp_addr.push_back(a + AW'(b) * BURST);
      exp_len.push_back((((len - b * 256) > 256) ? 256 : (len - b * 256)) - 1);
    end
    @(negedge clk);
    desc_dst_addr = a;
    desc_length   = NW'(len);
    desc_valid    = 1'b1;
    @(negedge clk);
    chk("busy_run", DW'(busy), DW'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    desc_valid = 1'b0;
    @(negedge clk);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic wait_done(input bit exp_rsp, input bit exp_seq, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (wr_fsm_done) seen = 1'b1;
    end
    chk("done_seen", DW'(seen), DW'(1));
    chk("rsp_err", DW'(wr_rsp_err), DW'(exp_rsp));
    chk("seq_err", DW'(seq_err), DW'(exp_seq));
    desc_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", DW'(wr_fsm_done), DW'(0));
    chk("busy_idle", DW'(busy), DW'(0));
    chk("done_cnt", DW'(n_done), DW'(1));
    chk("aw_cnt", DW'(n_aw), DW'(exp_addr.size()));
    chk("w_cnt", DW'(n_w), DW'(exp_data.size()));
    chk("pops", DW'(n_pop), DW'(exp_data.size()));
    chk("b_cnt", DW'(n_b), DW'(exp_addr.size()));
    chk("pend_max", DW'(max_pend <= 2), DW'(1));
    chk("rd_en_bad", DW'(rd_bad), DW'(0));
    if (!seen) do_reset();
  endtask

  // slave/FIFO side: inputs change on the falling edge only
  always @(negedge clk) begin
    axi.awready  = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    axi.wready   = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    fifo_empty   = (q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    fifo_rd_data = (q.size() > 0) ? q[0] : '0;
    axi.bvalid   = 1'b0;
    axi.bresp    = 2'b00;
    if (!bhold && b_due.size() > 0) begin
      if (cyc >= b_due[0]) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (b_idx[0] == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  // monitor/scoreboard on the rising edge
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (axi.awvalid && axi.awready) begin
        if (n_aw < exp_addr.size()) begin
          chk("awaddr", DW'(axi.awaddr), DW'(exp_addr[n_aw]));
          chk("awlen", DW'(axi.awlen), DW'(exp_len[n_aw]));
          aw_beats += exp_len[n_aw] + 1;
        end else chk("extra_aw", DW'(n_aw), DW'(exp_addr.size()));
        n_aw++;
      end
      if (axi.wvalid && axi.wready) begin
        chk("w_after_aw", DW'(n_w < aw_beats), DW'(1));
        if (n_w < exp_data.size()) begin
          chk("wdata", axi.wdata, exp_data[n_w]);
          chk("wlast", DW'(axi.wlast), DW'(exp_last[n_w]));
        end
        chk("rd_en", DW'(fifo_rd_en), DW'(1));
        if (axi.wlast) begin
          b_due.push_back(cyc + (gap_en ? int'($urandom_range(0, 3)) : 0));
          b_idx.push_back(n_wl);
          n_wl++;
        end
        n_w++;
      end else if (fifo_rd_en) rd_bad++;
      if (fifo_rd_en && q.size() > 0) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (axi.bvalid && b_due.size() > 0) begin
        n_b++;
        void'(b_due.pop_front());
        void'(b_idx.pop_front());
      end
      if (wr_fsm_done) n_done++;
      if (n_aw - n_b > max_pend) max_pend = n_aw - n_b;
    end
  end

  initial begin
    int lens[4];
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_awvalid", DW'(axi.awvalid), DW'(0));
    chk("rst_wvalid", DW'(axi.wvalid), DW'(0));
    chk("rst_rd_en", DW'(fifo_rd_en), DW'(0));
    chk("rst_done", DW'(wr_fsm_done), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_rsp_err", DW'(wr_rsp_err), DW'(0));
    chk("rst_seq_err", DW'(seq_err), DW'(0));
    chk("awsize", DW'(axi.awsize), DW'(6));
    chk("awburst", DW'(axi.awburst), DW'(1));
    chk("bready", DW'(axi.bready), DW'(1));
    chk("wstrb", DW'(axi.wstrb), DW'({64{1'b1}}));
    reset = 1'b0;
    @(negedge clk);

    // single beat
    start_desc(64'h1000, 1, 0);
    wait_done(1'b0, 1'b0, 200);

    // three bursts: 255, 255, 87
    start_desc(64'h20000, 600, 0);
    wait_done(1'b0, 1'b0, 3000);

    // no B responses: at most two bursts outstanding
    bhold = 1'b1;
    start_desc(64'h40000, 600, 0);
    repeat (700) @(negedge clk);
    chk("aw_held", DW'(n_aw), DW'(2));
    chk("b_held", DW'(n_b), DW'(0));
    chk("pend_reach", DW'(max_pend), DW'(2));
    bhold = 1'b0;
    wait_done(1'b0, 1'b0, 3000);

    // random FIFO/wready/awready/B gaps
    gap_en = 1'b1;
    start_desc(64'h80000, 300, 0);
    wait_done(1'b0, 1'b0, 6000);
    gap_en = 1'b0;

    // SLVERR on burst 2, then a clean descriptor clears the flag
    err_burst = 1;
    start_desc(64'h100000, 600, 0);
    wait_done(1'b1, 1'b0, 3000);
    err_burst = -1;
    start_desc(64'h4000, 5, 0);
    wait_done(1'b0, 1'b0, 200);

    // packet_complete missing / early
    start_desc(64'h8000, 4, 1);
    wait_done(1'b0, 1'b1, 200);
    start_desc(64'hC000, 4, 2);
    wait_done(1'b0, 1'b1, 200);

    // reset in the middle of SEND_DATA
    start_desc(64'h200000, 300, 0);
    for (int c = 0; c < 2000 && n_w < 50; c++) @(negedge clk);
    reset = 1'b1;
    desc_valid = 1'b0;
    @(negedge clk);
    chk("mid_awvalid", DW'(axi.awvalid), DW'(0));
    chk("mid_wvalid", DW'(axi.wvalid), DW'(0));
    chk("mid_rd_en", DW'(fifo_rd_en), DW'(0));
    chk("mid_done", DW'(wr_fsm_done), DW'(0));
    chk("mid_busy", DW'(busy), DW'(0));
    chk("mid_no_done", DW'(n_done), DW'(0));
    model_clear();
    reset = 1'b0;
    @(negedge clk);
    start_desc(64'h300000, 70, 0);
    wait_done(1'b0, 1'b0, 600);

    // boundary and random lengths
    lens[0] = 256; lens[1] = 512; lens[2] = 257; lens[3] = 0;
    for (int t = 0; t < 8; t++) begin
      int len;
      len    = (t < 3) ? lens[t] : int'($urandom_range(1, 700));
      gap_en = (t >= 3) ? bit'($urandom_range(0, 1)) : 1'b0;
      start_desc({34'($urandom_range(0, 255)), 16'h0, 14'h0}, len, 0);
      wait_done(1'b0, 1'b0, 6000);
    end
    gap_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
